// File: rtl/tdm_demux8_rx.sv
// tdm_demux8_rx
// Receive end of the 8:1 TDM link. Serial slot bits are written into a
// shadow word at the current slot index; when slot N-1 arrives the full
// word is published on dout with a one-cycle dout_valid pulse. A
// frame_start seen mid-frame aborts the partial frame (frame_err pulse)
// and restarts collection with that bit as slot 0.
//
// Handshake: din/frame_start are qualified by din_valid only. There is no
// ready; the receiver accepts every beat. A cycle with din_valid=0 is a
// stall in which all state holds. The dout/dout_valid pair is a
// valid-only output as well: consumers must take dout on the pulse.
//
// FSM visibility: busy is high exactly in COLLECT, and slot exposes the
// write index, so the full control state is observable on the ports.

module tdm_demux8_rx #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SEL_W-1:0] slot,
  output logic             busy,
  output logic [N-1:0]     dout,
  output logic             dout_valid,
  output logic             frame_err
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] ONE_SLOT  = SEL_W'(1);

  state_t           state, state_n;
  logic [SEL_W-1:0] slot_q, slot_n;
  logic [N-1:0]     shadow, shadow_n;
  logic [N-1:0]     dout_q, dout_n;
  logic             dv_q, dv_n;
  logic             err_q, err_n;

  // A beat is any cycle carrying a slot bit.
  logic beat;
  assign beat = din_valid;

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      slot_q <= '0;
      shadow <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      slot_q <= slot_n;
      shadow <= shadow_n;
      dout_q <= dout_n;
      dv_q   <= dv_n;
      err_q  <= err_n;
    end
  end

  // Next-state, slot write and publish decisions.
  always_comb begin
    state_n  = state;
    slot_n   = slot_q;
    shadow_n = shadow;
    dout_n   = dout_q;
    dv_n     = 1'b0;
    err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        // Only a frame_start beat opens a frame; stray bits are dropped.
        if (beat && frame_start) begin
          shadow_n[0] = din;
          slot_n      = ONE_SLOT;
          state_n     = COLLECT;
        end
      end

      COLLECT: begin
        if (beat) begin
          if (frame_start) begin
            // Early restart: abandon the partial frame, this bit is slot 0.
            err_n       = 1'b1;
            shadow_n[0] = din;
            slot_n      = ONE_SLOT;
          end else if (slot_q == LAST_SLOT) begin
            // Last slot: publish shadow with din in the top position.
            dout_n        = shadow;
            dout_n[N-1]   = din;
            dv_n          = 1'b1;
            slot_n        = '0;
            state_n       = IDLE;
          end else begin
            shadow_n[slot_q] = din;
            slot_n           = slot_q + ONE_SLOT;
          end
        end
      end

      default: begin
        state_n = IDLE;
        slot_n  = '0;
      end
    endcase
  end

  // Outputs are straight from registers.
  assign slot       = slot_q;
  assign busy       = (state == COLLECT);
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_tdm_demux8_rx.sv
// Directed bench for tdm_demux8_rx: reset, basic frame, stalls, early
// restart, back-to-back frames, reset mid-frame with stray IDLE beats.

module tb_tdm_demux8_rx;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic [2:0] slot;
  logic       busy;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;

  int n_checks;
  int n_fail;

  tdm_demux8_rx #(.N(8), .SEL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .slot        (slot),
    .busy        (busy),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_err   (frame_err)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs at negedge; return 1 time unit after posedge.
  task automatic cycle(input logic r, input logic v, input logic d, input logic fs);
    @(negedge clk);
    rst         = r;
    din_valid   = v;
    din         = d;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    n_checks++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", dout_valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    n_checks++;
    if (slot !== 3'd0) begin n_fail++; $display("FAIL reset_slot: got %0d expected 0", slot); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic_frame();
    logic [7:0] w;
    w = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, w[k], k == 0);
      n_checks++;
      if (dout_valid !== (k == 7)) begin
        n_fail++; $display("FAIL basic_dv[%0d]: got %b expected %b", k, dout_valid, k == 7);
      end
      n_checks++;
      if (slot !== ((k == 7) ? 3'd0 : 3'(k + 1))) begin
        n_fail++; $display("FAIL basic_slot[%0d]: got %0d expected %0d", k, slot, (k == 7) ? 0 : k + 1);
      end
      n_checks++;
      if (busy !== (k != 7)) begin
        n_fail++; $display("FAIL basic_busy[%0d]: got %b expected %b", k, busy, k != 7);
      end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_err[%0d]: got %b expected 0", k, frame_err); end
    end
    n_checks++;
    if (dout !== 8'hAA) begin n_fail++; $display("FAIL basic_dout: got %h expected aa", dout); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_dv_width: got %b expected 0", dout_valid); end
    n_checks++;
    if (dout !== 8'hAA) begin n_fail++; $display("FAIL basic_dout_hold: got %h expected aa", dout); end
  endtask

  task automatic test_stalls();
    logic [7:0] w;
    int pulses;
    w = 8'hAA;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, w[k], k == 0);
      if (dout_valid === 1'b1) pulses++;
      if (k < 7) begin
        for (int g = 0; g < 1 + (k % 3); g++) begin
          cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if (dout_valid === 1'b1) pulses++;
          n_checks++;
          if (slot !== 3'(k + 1)) begin
            n_fail++; $display("FAIL stall_slot[%0d]: got %0d expected %0d", k, slot, k + 1);
          end
          n_checks++;
          if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy[%0d]: got %b expected 1", k, busy); end
        end
      end
    end
    n_checks++;
    if (dout !== 8'hAA) begin n_fail++; $display("FAIL stall_dout: got %h expected aa", dout); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (dout_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL stall_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_early_restart();
    logic [7:0] a;
    logic [7:0] w;
    a = 8'hFF;
    w = 8'h0F;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, a[k], k == 0);
    n_checks++;
    if (slot !== 3'd4) begin n_fail++; $display("FAIL restart_pre_slot: got %0d expected 4", slot); end
    // Fifth beat carries frame_start: restart with slot 0 of 0F.
    cycle(1'b0, 1'b1, w[0], 1'b1);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL restart_err: got %b expected 1", frame_err); end
    n_checks++;
    if (slot !== 3'd1) begin n_fail++; $display("FAIL restart_slot: got %0d expected 1", slot); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b expected 1", busy); end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL restart_dv: got %b expected 0", dout_valid); end
    for (int k = 1; k < 8; k++) begin
      cycle(1'b0, 1'b1, w[k], 1'b0);
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL restart_err_after[%0d]: got %b expected 0", k, frame_err); end
      if (k < 7) begin
        n_checks++;
        if (dout !== 8'hAA) begin n_fail++; $display("FAIL restart_dout_hold[%0d]: got %h expected aa", k, dout); end
      end
    end
    n_checks++;
    if (dout !== 8'h0F) begin n_fail++; $display("FAIL restart_dout: got %h expected 0f", dout); end
    n_checks++;
    if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL restart_dv_end: got %b expected 1", dout_valid); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int first_pulse;
    int second_pulse;
    int errs;
    w = 16'hC33C;  // low byte 3C sent first, then C3
    first_pulse = -1;
    second_pulse = -1;
    errs = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b1, w[k], (k % 8) == 0);
      if (frame_err === 1'b1) errs++;
      if (dout_valid === 1'b1) begin
        if (first_pulse < 0) first_pulse = k;
        else if (second_pulse < 0) second_pulse = k;
      end
      if (k == 7) begin
        n_checks++;
        if (dout !== 8'h3C) begin n_fail++; $display("FAIL b2b_dout1: got %h expected 3c", dout); end
        n_checks++;
        if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_dv1: got %b expected 1", dout_valid); end
      end
      if (k == 8) begin
        n_checks++;
        if (busy !== 1'b1 || slot !== 3'd1) begin
          n_fail++; $display("FAIL b2b_restart: got busy=%b slot=%0d expected busy=1 slot=1", busy, slot);
        end
      end
    end
    n_checks++;
    if (dout !== 8'hC3) begin n_fail++; $display("FAIL b2b_dout2: got %h expected c3", dout); end
    n_checks++;
    if (second_pulse - first_pulse !== 8 || first_pulse !== 7) begin
      n_fail++; $display("FAIL b2b_spacing: got pulses at %0d,%0d expected 7,15", first_pulse, second_pulse);
    end
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL b2b_err: got %0d expected 0", errs); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    int pulses;
    w = 8'h55;
    pulses = 0;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, w[k], k == 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL rstmid_dout: got %h expected 00", dout); end
    n_checks++;
    if (busy !== 1'b0 || slot !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_state: got busy=%b slot=%0d expected busy=0 slot=0", busy, slot);
    end
    n_checks++;
    if (dout_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_pulses: got dv=%b err=%b expected 0 0", dout_valid, frame_err);
    end
    // Stray beats in IDLE, plus frame_start without din_valid.
    for (int i = 0; i < 6; i++) begin
      if (i == 3) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      else cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      if (dout_valid === 1'b1 || frame_err === 1'b1) pulses++;
      n_checks++;
      if (slot !== 3'd0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL stray_state[%0d]: got busy=%b slot=%0d expected busy=0 slot=0", i, busy, slot);
      end
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL stray_pulses: got %0d expected 0", pulses); end
    n_checks++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL stray_dout: got %h expected 00", dout); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    din         = 1'b0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    test_reset();
    test_basic_frame();
    test_stalls();
    test_early_restart();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
